fetch_exec_ctrl: RTL and testbench

//   Moore FSM that sequences the RISC machine around the single-port-per-cycle RAM,
//   the program counter and its next-PC / memory-address muxes.

---
 rtl/fetch_exec_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_exec_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_ctrl.sv
// Moore sequencer for the RISC machine: fetch, PC update, decode, then execute,
// load or store, ending in HALT or FAULT.
module fetch_exec_ctrl #(
  parameter int unsigned MAX_EXEC_CYCLES = 15,
  parameter int unsigned CNT_WIDTH       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       exec_done,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       load_ir,
  output logic       load_addr,
  output logic       wb_mem,
  output logic       exec_start,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    RST       = 4'd0,
    IF1       = 4'd1,
    IF2       = 4'd2,
    UPD_PC    = 4'd3,
    DECODE    = 4'd4,
    EXEC_ST   = 4'd5,
    EXEC_WAIT = 4'd6,
    LD_ADDR   = 4'd7,
    MEM_RD    = 4'd8,
    MEM_WB    = 4'd9,
    MEM_WR    = 4'd10,
    HALT      = 4'd11,
    FAULT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       reset_pc;
    logic       load_pc;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       load_ir;
    logic       load_addr;
    logic       wb_mem;
    logic       exec_start;
    logic       halted;
    logic       fault;
  } ctrl_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(MAX_EXEC_CYCLES);

  state_t               state, state_nxt;
  ctrl_t                ctrl;
  logic [CNT_WIDTH-1:0] wd, wd_nxt, wd_inc;
  logic                 is_load, is_load_nxt;

  // Control word for a given state; registered alongside the state so outputs
  // change on the same edge as state_out.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    c.mem_cmd = CMD_NONE;
    case (s)
      RST:     begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      IF1:     begin c.addr_sel = 1'b1; c.mem_cmd = CMD_READ; end
      IF2:     begin c.addr_sel = 1'b1; c.mem_cmd = CMD_READ; c.load_ir = 1'b1; end
      UPD_PC:  c.load_pc = 1'b1;
      EXEC_ST: c.exec_start = 1'b1;
      LD_ADDR: c.load_addr = 1'b1;
      MEM_RD:  c.mem_cmd = CMD_READ;
      MEM_WB:  begin c.mem_cmd = CMD_READ; c.wb_mem = 1'b1; end
      MEM_WR:  c.mem_cmd = CMD_WRITE;
      HALT:    c.halted = 1'b1;
      FAULT:   c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd;
    is_load_nxt = is_load;
    wd_inc      = (wd == '1) ? wd : wd + CNT_WIDTH'(1);
    case (state)
      RST:     state_nxt = IF1;
      IF1:     state_nxt = IF2;
      IF2:     state_nxt = UPD_PC;
      UPD_PC:  state_nxt = DECODE;
      DECODE: begin
        is_load_nxt = (opcode == 3'b011);
        case (opcode)
          3'b111:         state_nxt = HALT;
          3'b011, 3'b100: state_nxt = LD_ADDR;
          default:        state_nxt = EXEC_ST;
        endcase
      end
      EXEC_ST: begin
        state_nxt = EXEC_WAIT;
        wd_nxt    = '0;
      end
      EXEC_WAIT: begin
        if (exec_done) begin
          state_nxt = IF1;
        end else begin
          wd_nxt = wd_inc;
          if (wd_inc >= WD_LIMIT) state_nxt = FAULT;
        end
      end
      LD_ADDR: state_nxt = is_load ? MEM_RD : MEM_WR;
      MEM_RD:  state_nxt = MEM_WB;
      MEM_WB:  state_nxt = IF1;
      MEM_WR:  state_nxt = IF1;
      HALT:    state_nxt = HALT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RST;
      wd      <= '0;
      is_load <= 1'b0;
      ctrl    <= ctrl_for(RST);
    end else begin
      state   <= state_nxt;
      wd      <= wd_nxt;
      is_load <= is_load_nxt;
      ctrl    <= ctrl_for(state_nxt);
    end
  end

  assign reset_pc   = ctrl.reset_pc;
  assign load_pc    = ctrl.load_pc;
  assign addr_sel   = ctrl.addr_sel;
  assign mem_cmd    = ctrl.mem_cmd;
  assign load_ir    = ctrl.load_ir;
  assign load_addr  = ctrl.load_addr;
  assign wb_mem     = ctrl.wb_mem;
  assign exec_start = ctrl.exec_start;
  assign halted     = ctrl.halted;
  assign fault      = ctrl.fault;
  assign state_out  = state;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Scoreboard bench: an instruction-level model plans the expected state per cycle,
// a monitor compares state and control outputs against the state's output table.
module tb_fetch_exec_ctrl;

  localparam int S_RST = 0, S_IF1 = 1, S_IF2 = 2, S_UPD = 3, S_DEC = 4, S_EXST = 5,
                 S_EW = 6, S_LD = 7, S_RD = 8, S_WB = 9, S_WR = 10, S_HALT = 11,
                 S_FAULT = 12;
  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] opcode = '0;
  logic       exec_done = 1'b0;
  logic       reset_pc, load_pc, addr_sel, load_ir, load_addr, wb_mem;
  logic       exec_start, halted, fault;
  logic [1:0] mem_cmd;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic done;
    int   nxt;
  } plan_t;

  fetch_exec_ctrl #(.MAX_EXEC_CYCLES(15), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .exec_done(exec_done),
    .reset_pc(reset_pc), .load_pc(load_pc), .addr_sel(addr_sel), .mem_cmd(mem_cmd),
    .load_ir(load_ir), .load_addr(load_addr), .wb_mem(wb_mem), .exec_start(exec_start),
    .halted(halted), .fault(fault), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // {reset_pc, load_pc, addr_sel, mem_cmd[1:0], load_ir, load_addr, wb_mem, exec_start, halted, fault}
  function automatic logic [10:0] exp_outs(input int s);
    case (s)
      S_RST:   return 11'b110_00_000000;
      S_IF1:   return 11'b001_01_000000;
      S_IF2:   return 11'b001_01_100000;
      S_UPD:   return 11'b010_00_000000;
      S_EXST:  return 11'b000_00_000100;
      S_LD:    return 11'b000_00_010000;
      S_RD:    return 11'b000_01_000000;
      S_WB:    return 11'b000_01_001000;
      S_WR:    return 11'b000_10_000000;
      S_HALT:  return 11'b000_00_000010;
      S_FAULT: return 11'b000_00_000001;
      default: return 11'b000_00_000000;
    endcase
  endfunction

  // Drive inputs for the next rising edge and record the state expected after it.
  task automatic step(input logic rst, input logic [2:0] op, input logic done, input int exp);
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    exec_done = done;
    exp_q.push_back(exp);
  endtask

  // Plays one instruction starting from IF1. n_wait: EXEC_WAIT cycle carrying exec_done
  // (0 = never). abort_at > 0 replaces that planned step with a reset cycle.
  task automatic run_instr(input logic [2:0] op, input int n_wait, input int abort_at,
                           input logic abort_done);
    plan_t plan[$];
    plan_t p;
    int    last;
    foreach (plan[i]) plan.delete(i);
    p.done = 1'($urandom_range(0, 1)); p.nxt = S_IF2; plan.push_back(p);
    p.done = 1'($urandom_range(0, 1)); p.nxt = S_UPD; plan.push_back(p);
    p.done = 1'($urandom_range(0, 1)); p.nxt = S_DEC; plan.push_back(p);
    case (op)
      3'b011: begin
        foreach (plan[i]) ;
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_LD; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_RD; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_WB; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_IF1; plan.push_back(p);
      end
      3'b100: begin
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_LD; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_WR; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_IF1; plan.push_back(p);
      end
      3'b111: begin
        for (int k = 0; k < 21; k++) begin
          p.done = 1'($urandom_range(0, 1)); p.nxt = S_HALT; plan.push_back(p);
        end
      end
      default: begin
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_EXST; plan.push_back(p);
        p.done = 1'($urandom_range(0, 1)); p.nxt = S_EW; plan.push_back(p);
        for (int k = 1; k <= MAX_WAIT; k++) begin
          p.done = (k == n_wait);
          p.nxt  = p.done ? S_IF1 : ((k == MAX_WAIT) ? S_FAULT : S_EW);
          plan.push_back(p);
          if (p.done) break;
        end
        if (n_wait == 0) begin
          for (int k = 0; k < 3; k++) begin
            p.done = 1'($urandom_range(0, 1)); p.nxt = S_FAULT; plan.push_back(p);
          end
        end
      end
    endcase

    for (int i = 0; i < plan.size(); i++) begin
      if (abort_at > 0 && i == abort_at) begin
        step(1'b0, op, abort_done, S_RST);
        step(1'b1, op, 1'b0, S_IF1);
        return;
      end
      // opcode only has to be valid from the cycle after IF2
      step(1'b1, (i < 2) ? 3'($urandom_range(0, 7)) : op, plan[i].done, plan[i].nxt);
    end
    last = plan[plan.size()-1].nxt;
    if (last == S_HALT || last == S_FAULT) begin
      step(1'b0, op, 1'($urandom_range(0, 1)), S_RST);
      step(1'b1, op, 1'b0, S_IF1);
    end
  endtask

  int          mon_s;
  logic [10:0] mon_got;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_s   = exp_q.pop_front();
      mon_got = {reset_pc, load_pc, addr_sel, mem_cmd, load_ir, load_addr, wb_mem,
                 exec_start, halted, fault};
      checks++;
      if (state_out !== 4'(mon_s)) begin
        errors++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_out, mon_s);
      end
      checks++;
      if (mon_got !== exp_outs(mon_s)) begin
        errors++;
        $display("FAIL outputs t=%0t state=%0d got=%b exp=%b", $time, mon_s, mon_got,
                 exp_outs(mon_s));
      end
    end
  end

  initial begin
    logic [2:0] op;
    int         nw;
    step(1'b0, 3'b000, 1'b0, S_RST);
    step(1'b0, 3'b000, 1'b1, S_RST);
    step(1'b1, 3'b000, 1'b0, S_IF1);

    run_instr(3'b011, 0, 0, 1'b0);   // LDR
    run_instr(3'b100, 0, 0, 1'b0);   // STR
    run_instr(3'b101, 3, 0, 1'b0);   // ALU, done on 3rd wait cycle
    run_instr(3'b101, 0, 0, 1'b0);   // watchdog expiry
    run_instr(3'b110, 15, 0, 1'b0);  // done on the expiry cycle wins
    run_instr(3'b111, 0, 0, 1'b0);   // HALT
    run_instr(3'b100, 0, 5, 1'b0);   // reset while in MEM_WR
    run_instr(3'b101, 0, 19, 1'b1);  // reset in EXEC_WAIT at watchdog 14 with done
    run_instr(3'b000, 0, 0, 1'b0);   // watchdog restarts from 0 after that reset

    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b010;
      nw = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAX_WAIT));
      run_instr(op, nw, 0, 1'b0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
